// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types for the register-file write arbiter and its result buffer
package regfile_pkg;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef enum logic {NORMAL, DRAIN} arb_state_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback, MDU and register-file write-port signals
interface rf_write_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] pending_mask;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    modport master (
        output wb_valid, wb_addr, wb_data, issue_valid, issue_addr, mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready, pending_mask, pipe_stall, rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  wb_valid, wb_addr, wb_data, issue_valid, issue_addr, mdu_valid, mdu_addr, mdu_data,
        output mdu_ready, pending_mask, pipe_stall, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: power-of-two deep buffer of MDU results; only the head is visible
module rf_wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  wb_req_t                      data_i,
    input  logic                         pop_i,
    output wb_req_t                      head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    wb_req_t       mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          push;
    assign ready_o = cnt_q < FULL;
    assign push    = valid_i && ready_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between writeback and the MDU,
// tracking outstanding MDU destinations and forcing a drain when the MDU starves.
module rf_write_arbiter
    import regfile_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    arb_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0] pend_q, pend_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    wb_req_t     head, mdu_req;
    logic [$clog2(FIFO_DEPTH+1)-1:0] count;
    logic        empty, grant_wb, grant_mdu;
    assign mdu_req = {bus.mdu_addr, bus.mdu_data};
    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.mdu_valid),
        .ready_o (bus.mdu_ready),
        .data_i  (mdu_req),
        .pop_i   (grant_mdu),
        .head_o  (head),
        .count_o (count)
    );
    // The counter only grows while WB beats a non-empty buffer, so reaching LIMIT means starvation
    always_comb begin
        empty     = count == '0;
        grant_wb  = state_q == NORMAL && bus.wb_valid;
        grant_mdu = !empty && (state_q == DRAIN || !bus.wb_valid);
        starve_d  = (state_q == DRAIN || grant_mdu || empty) ? '0 :
                    (starve_q == LIMIT) ? starve_q : starve_q + SW'(1);
        state_d   = (state_q == NORMAL && starve_d == LIMIT) ? DRAIN : NORMAL;
        waddr_d   = grant_mdu ? head.addr : grant_wb ? bus.wb_addr : waddr_q;
        wdata_d   = grant_mdu ? head.data : grant_wb ? bus.wb_data : wdata_q;
        we_d      = (grant_mdu || grant_wb) && waddr_d != REG_ZERO;
        pend_d    = (pend_q & ~(grant_mdu ? 32'(1) << head.addr : 32'(0)))
                  | ((bus.issue_valid && bus.issue_addr != REG_ZERO) ? 32'(1) << bus.issue_addr : 32'(0));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            starve_q <= '0;
            pend_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end
    assign bus.pending_mask = pend_q;
    assign bus.pipe_stall   = state_q == DRAIN;
    assign bus.rf_we        = we_q;
    assign bus.rf_waddr     = waddr_q;
    assign bus.rf_wdata     = wdata_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus, queue-based reference model and literal spot checks
module tb_rf_write_arbiter;
    import regfile_pkg::*;
    localparam int STARVE = 4;
    localparam int DEPTH  = 2;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    rf_write_arbiter_if bus ();
    rf_write_arbiter #(.STARVE_LIMIT(STARVE), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered results, a pending bitmap and a starvation tally
    wb_req_t     q[$];
    logic [31:0] m_pend;
    bit          m_drain, en;
    int          m_starve;
    logic        e_we, e_ready, e_stall;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    always @(posedge clk) begin
        int n;
        bit gw, gm;
        wb_req_t w;
        en = 1;
        if (rst) begin
            q.delete();
            m_pend = '0; m_drain = 0; m_starve = 0;
            e_we = 0; e_waddr = '0; e_wdata = '0;
        end else begin
            n  = q.size();
            gw = !m_drain && bus.wb_valid;
            gm = n > 0 && (m_drain || !bus.wb_valid);
            w  = '{addr: bus.wb_addr, data: bus.wb_data};
            if (gm) begin
                w = q.pop_front();
                m_pend[w.addr] = 1'b0;
            end
            e_we = (gw || gm) && w.addr != 5'd0;
            if (gw || gm) begin
                e_waddr = w.addr;
                e_wdata = w.data;
            end
            if (m_drain) begin
                m_drain = 0;
                m_starve = 0;
            end else if (gm || n == 0) m_starve = 0;
            else begin
                m_starve++;
                m_drain = m_starve == STARVE;
            end
            if (bus.mdu_valid && n < DEPTH) q.push_back('{addr: bus.mdu_addr, data: bus.mdu_data});
            if (bus.issue_valid && bus.issue_addr != 5'd0) m_pend[bus.issue_addr] = 1'b1;
        end
        e_ready = q.size() < DEPTH;
        e_stall = m_drain;
    end

    always @(negedge clk) begin
        if (en) begin
            check("m_rf_we", bus.rf_we, e_we);
            check("m_stall", bus.pipe_stall, e_stall);
            check("m_pend", bus.pending_mask, m_pend);
            check("m_ready", bus.mdu_ready, e_ready);
            if (e_we) begin
                check("m_waddr", bus.rf_waddr, e_waddr);
                check("m_wdata", bus.rf_wdata, e_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.issue_valid = 0; bus.issue_addr = '0;
        bus.mdu_valid = 0; bus.mdu_addr = '0; bus.mdu_data = '0;
    endtask

    initial begin
        int idx;
        logic r;
        rst = 1;
        idle();
        repeat (2) tick();
        check("rst_we", bus.rf_we, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_pend", bus.pending_mask, 0);
        check("rst_stall", bus.pipe_stall, 0);
        rst = 0;
        tick();
        check("rst_ready", bus.mdu_ready, 1);
        // plain writeback
        bus.wb_valid = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
        tick(); idle();
        check("t1_we", bus.rf_we, 1);
        check("t1_waddr", bus.rf_waddr, 5);
        check("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("t1_pend", bus.pending_mask, 0);
        bus.wb_valid = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1;
        tick(); idle();
        check("t1_r0_we", bus.rf_we, 0);
        // scoreboard set then clear with the MDU write
        bus.issue_valid = 1; bus.issue_addr = 5'd7;
        tick(); idle();
        check("t2_pend_set", bus.pending_mask, 32'h80);
        bus.mdu_valid = 1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'd42;
        tick(); idle();
        check("t2_pend_hold", bus.pending_mask, 32'h80);
        check("t2_no_bypass", bus.rf_we, 0);
        tick();
        check("t2_we", bus.rf_we, 1);
        check("t2_waddr", bus.rf_waddr, 7);
        check("t2_wdata", bus.rf_wdata, 42);
        check("t2_pend_clr", bus.pending_mask, 0);
        // starvation guard with WB held high
        bus.wb_valid = 1; bus.wb_addr = 5'd10; bus.wb_data = 32'hA0;
        bus.mdu_valid = 1; bus.mdu_addr = 5'd3; bus.mdu_data = 32'h33;
        tick();
        bus.mdu_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t3_stall", bus.pipe_stall, 32'(k == 4));
            if (k == 5) begin
                check("t3_drain_we", bus.rf_we, 1);
                check("t3_drain_waddr", bus.rf_waddr, 3);
                check("t3_drain_wdata", bus.rf_wdata, 32'h33);
            end
            if (k == 6) check("t3_wb_resume", bus.rf_waddr, 10);
        end
        idle();
        tick();
        // three back-to-back MDU results during continuous WB
        bus.wb_valid = 1; bus.wb_addr = 5'd11; bus.wb_data = 32'hB0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            bus.mdu_valid = idx < 3;
            bus.mdu_addr  = 5'(14 + idx);
            bus.mdu_data  = 32'(32'h140 + idx);
            r = bus.mdu_ready;
            if (c == 2) check("t4_ready_full", r, 0);
            if (c == 5) begin
                check("t4_stall", bus.pipe_stall, 1);
                check("t4_ready_stall", r, 0);
            end
            if (c == 6) begin
                check("t4_ready_drained", r, 1);
                check("t4_first_drain", bus.rf_waddr, 14);
                check("t4_third_waiting", idx, 2);
            end
            tick();
            if (r && idx < 3) idx++;
        end
        check("t4_all_accepted", idx, 3);
        idle();
        repeat (6) tick();
        // write to register 0, then same-cycle set/clear
        bus.mdu_valid = 1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'h55;
        tick(); idle();
        tick();
        check("t5_r0_we", bus.rf_we, 0);
        check("t5_r0_ready", bus.mdu_ready, 1);
        bus.issue_valid = 1; bus.issue_addr = 5'd9;
        tick(); idle();
        bus.mdu_valid = 1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'd9;
        tick(); idle();
        bus.issue_valid = 1; bus.issue_addr = 5'd9;
        tick(); idle();
        check("t5_clr_we", bus.rf_we, 1);
        check("t5_clr_waddr", bus.rf_waddr, 9);
        check("t5_set_wins", bus.pending_mask, 32'h200);
        // reset with buffered results and pending bits
        bus.issue_valid = 1; bus.issue_addr = 5'd12;
        tick();
        bus.issue_addr = 5'd13;
        tick(); idle();
        bus.wb_valid = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'h1;
        bus.mdu_valid = 1; bus.mdu_addr = 5'd12; bus.mdu_data = 32'hC;
        tick();
        bus.mdu_addr = 5'd13; bus.mdu_data = 32'hD;
        tick();
        bus.mdu_valid = 0;
        check("t6_full", bus.mdu_ready, 0);
        check("t6_pend", bus.pending_mask, 32'h3200);
        rst = 1; idle();
        tick();
        check("t6_ready", bus.mdu_ready, 1);
        check("t6_pend_clr", bus.pending_mask, 0);
        check("t6_we", bus.rf_we, 0);
        check("t6_stall", bus.pipe_stall, 0);
        rst = 0;
        repeat (3) tick();
        check("t6_discarded", bus.rf_we, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
